// File: rtl/division.sv
// Restoring unsigned divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Zero-divisor and quotient-overflow cases bypass the iteration and complete in one cycle.
module division #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           overflow
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | shifting out one quotient bit per cycle
    // DONE  | results valid, done pulse; start accepted back-to-back
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CW = $clog2(W);

    state_t          state;
    logic [W-1:0]    r;
    logic [W-1:0]    q;
    logic [W-1:0]    dvs;
    logic [CW-1:0]   count;

    logic [W:0]      t;
    logic [W-1:0]    r_nxt;
    logic [W-1:0]    q_nxt;
    logic            q_bit;

    // The partial remainder stays below the divisor, so the W+1 bit trial fits.
    always_comb begin
        t     = {r, q[W-1]};
        q_bit = 1'b0;
        r_nxt = t[W-1:0];
        if (t >= {1'b0, dvs}) begin
            q_bit = 1'b1;
            r_nxt = W'(t - {1'b0, dvs});
        end
        q_nxt = {q[W-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            q         <= '0;
            dvs       <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[W-1:0];
                            div_zero  <= 1'b1;
                            overflow  <= 1'b0;
                        end else if (dividend[2*W-1:W] >= divisor) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b0;
                            overflow  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            r     <= dividend[2*W-1:W];
                            q     <= dividend[W-1:0];
                            dvs   <= divisor;
                            count <= CW'(W - 1);
                        end
                    end
                end
                RUN: begin
                    r     <= r_nxt;
                    q     <= q_nxt;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
                        div_zero  <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_division.sv
// Scoreboard bench for the divider: expected results queued at start, checked on done.
module tb_division;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;
    logic           overflow;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dz;
        logic           ov;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    division #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: compare every done pulse against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (done) begin
            check_eq("busy_done_excl", {127'd0, busy}, 128'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("quotient", quotient, e.q);
                check_eq("remainder", remainder, e.r);
                check_eq("flags", {div_zero, overflow}, {e.dz, e.ov});
                if (!e.dz && !e.ov) begin
                    check_eq("identity", 64'(quotient) * 64'(e.dvs) + 64'(remainder), e.dvd);
                    check_eq("rem_lt_div", {127'd0, remainder < e.dvs}, 128'd1);
                end
            end
        end
    end

    // Drive start for one cycle and queue the reference result; returns expected latency.
    task automatic start_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int lat);
        exp_t e;
        e.dvd = dvd;
        e.dvs = dvs;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (dvs == '0) begin
            e.dz = 1'b1; e.q = '1; e.r = dvd[W-1:0]; lat = 1;
        end else if (dvd[2*W-1:W] >= dvs) begin
            e.ov = 1'b1; e.q = '1; e.r = '0; lat = 1;
        end else begin
            e.q = W'(dvd / 64'(dvs));
            e.r = W'(dvd % 64'(dvs));
            lat = W + 1;
        end
        sb.push_back(e);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 'x;
        divisor  = 'x;
    endtask

    // Wait (bounded) for done; c0 is the cycle index we are in now relative to the start cycle.
    task automatic wait_done(input int c0, input int exp_lat);
        int c = c0;
        bit busy_ok = 1'b1;
        while (!done && c <= 80) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        check_eq("latency", 128'(c), 128'(exp_lat));
        if (exp_lat > 1) check_eq("busy_while_run", {127'd0, busy_ok}, 128'd1);
        else check_eq("busy_err_path", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_busy", {127'd0, busy}, 128'd0);
        check_eq("rst_done", {127'd0, done}, 128'd0);
        check_eq("rst_quot", quotient, 128'd0);
        check_eq("rst_rem", remainder, 128'd0);
        check_eq("rst_flags", {div_zero, overflow}, 128'd0);

        start_op(64'd100, 32'd7, lat);                 wait_done(1, lat);
        start_op(64'hFFFFFFFE_00000001, 32'hFFFFFFFF, lat); wait_done(1, lat);
        start_op(64'h12345678, 32'd0, lat);            wait_done(1, lat);
        start_op(64'h1_00000000, 32'd1, lat);          wait_done(1, lat);

        // Start while busy is ignored; then restart in the done cycle.
        start_op(64'd100, 32'd7, lat);
        repeat (9) begin @(posedge clk); #1; end
        dividend = 64'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(11, lat);
        start_op(64'd50, 32'd5, lat);                  wait_done(1, lat);

        // Reset mid-run aborts silently.
        start_op(64'd100, 32'd7, lat);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1; start = 1'b1; dividend = 64'd9; divisor = 32'd4;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        void'(sb.pop_back());
        check_eq("abort_busy", {127'd0, busy}, 128'd0);
        check_eq("abort_done", {127'd0, done}, 128'd0);
        check_eq("abort_quot", quotient, 128'd0);
        repeat (40) begin @(posedge clk); #1; end
        check_eq("abort_no_done", 128'(sb.size()), 128'd0);
        start_op(64'd9, 32'd4, lat);                   wait_done(1, lat);

        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] d, hi, lo;
            d  = (i % 4 == 0) ? W'($urandom_range(255, 1)) : W'($urandom);
            if (d == '0) d = 32'd1;
            hi = W'($urandom) % d;
            lo = W'($urandom);
            start_op({hi, lo}, d, lat);
            wait_done(1, lat);
        end

        repeat (5) begin @(posedge clk); #1; end
        check_eq("sb_empty", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
